buffer_n_ctrl: RTL and testbench

- Sequencer for the NORTH bridge buffer between linear projection and the Qn x KnT matmul.
- Write side: consumes projection beats (valid/ready) and sweeps the buffer's slicing_idx over every module slice of each beat, generating Port A enables and addresses.
- Read side: after the whole matrix is stored, streams it out of Port B to the matmul with valid/ready backpressure, NUM_READ_PASSES times. It then re-arms for the next head.
- Controls only; data buses connect directly between producer, buffer and consumer.

---
 rtl/buffer_n_ctrl.sv | 102 ++++++++++
 tb/tb_buffer_n_ctrl.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/buffer_n_ctrl.sv
// buffer_n_ctrl: NORTH bridge buffer sequencer; sliced Port A fill, then multi-pass Port B stream-out with backpressure.
module buffer_n_ctrl #(
    parameter int TOTAL_MODULES   = 3,
    parameter int NUM_BEATS       = 4,
    parameter int NUM_READ_PASSES = 2,
    parameter int ROW_X           = 16,
    parameter int COL_X           = 10,
    localparam int TOTAL_DEPTH    = ROW_X * COL_X,
    localparam int ADDR_WIDTH     = $clog2(TOTAL_DEPTH),
    localparam int IDX_WIDTH      = TOTAL_MODULES > 1 ? $clog2(TOTAL_MODULES) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [IDX_WIDTH-1:0]  slicing_idx,
    output logic                  bank0_ena,
    output logic                  bank0_wea,
    output logic [ADDR_WIDTH-1:0] bank0_addra,
    output logic                  bank0_enb,
    output logic [ADDR_WIDTH-1:0] bank0_addrb,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  done
);
    localparam int USED_DEPTH = TOTAL_MODULES * NUM_BEATS;
    localparam int BEAT_W     = NUM_BEATS > 1 ? $clog2(NUM_BEATS) : 1;
    localparam int RD_W       = $clog2(USED_DEPTH + 1);
    localparam int PASS_W     = $clog2(NUM_READ_PASSES + 1);

    if (USED_DEPTH > TOTAL_DEPTH) begin : g_depth_check
        $error("buffer_n_ctrl: TOTAL_MODULES*NUM_BEATS exceeds ROW_X*COL_X");
    end

    typedef enum logic {S_WRITE, S_READ} state_t;

    state_t              state, state_nxt;
    logic [IDX_WIDTH-1:0] idx_cnt;
    logic [BEAT_W-1:0]    beat_cnt;
    logic [RD_W-1:0]      rd_addr;
    logic [PASS_W-1:0]    pass_cnt;
    logic                 wr_go, idx_last, beat_last, issue, rd_last, final_acc;

    always_comb begin
        wr_go       = rst_n && state == S_WRITE && in_valid;
        idx_last    = idx_cnt == IDX_WIDTH'(TOTAL_MODULES - 1);
        beat_last   = beat_cnt == BEAT_W'(NUM_BEATS - 1);
        issue       = rst_n && state == S_READ && rd_addr < RD_W'(USED_DEPTH) && (!out_valid || out_ready);
        rd_last     = rd_addr == RD_W'(USED_DEPTH - 1);
        final_acc   = state == S_READ && out_valid && out_ready && out_last && pass_cnt == PASS_W'(NUM_READ_PASSES);
        in_ready    = wr_go && idx_last;
        bank0_ena   = wr_go;
        bank0_wea   = wr_go;
        slicing_idx = idx_cnt;
        // module-major layout: each slice owns a contiguous run of NUM_BEATS words
        bank0_addra = ADDR_WIDTH'(32'(idx_cnt) * NUM_BEATS + 32'(beat_cnt));
        bank0_enb   = issue;
        bank0_addrb = ADDR_WIDTH'(rd_addr);
        state_nxt   = state;
        if (wr_go && idx_last && beat_last) state_nxt = S_READ;
        if (final_acc) state_nxt = S_WRITE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_WRITE;
            idx_cnt   <= '0;
            beat_cnt  <= '0;
            rd_addr   <= '0;
            pass_cnt  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            done      <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= final_acc;
            if (wr_go) begin
                idx_cnt <= idx_last ? '0 : idx_cnt + 1'b1;
                if (idx_last) beat_cnt <= beat_last ? '0 : beat_cnt + 1'b1;
            end
            if (issue) begin
                out_valid <= 1'b1;
                out_last  <= rd_last;
                if (rd_last) begin
                    pass_cnt <= pass_cnt + 1'b1;
                    // parking at USED_DEPTH blocks issue until the final word drains
                    rd_addr  <= pass_cnt == PASS_W'(NUM_READ_PASSES - 1) ? RD_W'(USED_DEPTH) : '0;
                end else begin
                    rd_addr <= rd_addr + 1'b1;
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
            if (final_acc) begin
                pass_cnt <= '0;
                rd_addr  <= '0;
            end
        end
    end
endmodule

// File: tb/tb_buffer_n_ctrl.sv
// tb_buffer_n_ctrl: directed checks of fill, read, backpressure and reset for buffer_n_ctrl.
module tb_buffer_n_ctrl;
    logic       clk = 1'b0;
    logic       rst_n, in_valid, out_ready;
    logic       in_ready, bank0_ena, bank0_wea, bank0_enb, out_valid, out_last, done;
    logic [1:0] slicing_idx;
    logic [3:0] bank0_addra, bank0_addrb;
    int         checks = 0;
    int         failures = 0;

    buffer_n_ctrl #(
        .TOTAL_MODULES(3), .NUM_BEATS(4), .NUM_READ_PASSES(2), .ROW_X(4), .COL_X(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .slicing_idx(slicing_idx), .bank0_ena(bank0_ena), .bank0_wea(bank0_wea),
        .bank0_addra(bank0_addra), .bank0_enb(bank0_enb), .bank0_addrb(bank0_addrb),
        .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input bit gap);
        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < 3; i++) begin
                if (gap && b == 1 && i == 1) begin
                    in_valid = 1'b0;
                    repeat (2) begin
                        @(negedge clk);
                        check("gap_ena", bank0_ena, 0);
                        check("gap_ready", in_ready, 0);
                        check("gap_idx", slicing_idx, 1);
                        check("gap_addra", bank0_addra, 5);
                        step();
                    end
                    in_valid = 1'b1;
                end
                @(negedge clk);
                check("wr_ena", bank0_ena, 1);
                check("wr_wea", bank0_wea, 1);
                check("wr_idx", slicing_idx, i);
                check("wr_addra", bank0_addra, i * 4 + b);
                check("wr_ready", in_ready, i == 2 ? 1 : 0);
                check("wr_enb", bank0_enb, 0);
                step();
            end
        end
    endtask

    initial begin
        int cur_word, exp_seq, cyc;
        rst_n = 1'b0;
        in_valid = 1'b1;
        out_ready = 1'b0;
        step();
        repeat (2) begin
            @(negedge clk);
            check("rst_ready", in_ready, 0);
            check("rst_ena", bank0_ena, 0);
            check("rst_wea", bank0_wea, 0);
            check("rst_enb", bank0_enb, 0);
            check("rst_valid", out_valid, 0);
            check("rst_last", out_last, 0);
            check("rst_done", done, 0);
            check("rst_idx", slicing_idx, 0);
            check("rst_addra", bank0_addra, 0);
            check("rst_addrb", bank0_addrb, 0);
            step();
        end
        rst_n = 1'b1;
        fill(1'b1);
        out_ready = 1'b1;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            check("rd_enb", bank0_enb, k < 24 ? 1 : 0);
            if (k < 24) check("rd_addrb", bank0_addrb, k % 12);
            check("rd_valid", out_valid, k >= 1 ? 1 : 0);
            check("rd_last", out_last, (k == 12 || k == 24) ? 1 : 0);
            check("rd_ena", bank0_ena, 0);
            check("rd_in_ready", in_ready, 0);
            check("rd_done", done, 0);
            step();
        end
        check("done_pulse", done, 1);
        check("post_valid", out_valid, 0);
        fill(1'b0);
        check("done_cleared", done, 0);
        exp_seq = 0;
        cur_word = -1;
        cyc = 0;
        while (exp_seq < 24 && cyc < 200) begin
            out_ready = (cyc % 3) == 0;
            @(negedge clk);
            if (out_valid && !out_ready) check("bp_enb_stall", bank0_enb, 0);
            if (out_valid && out_ready) begin
                check("bp_word", cur_word, exp_seq % 12);
                check("bp_last", out_last, (exp_seq % 12) == 11 ? 1 : 0);
                exp_seq++;
            end
            if (bank0_enb) cur_word = bank0_addrb;
            check("bp_no_early_done", done, 0);
            step();
            cyc++;
        end
        check("bp_accepts", exp_seq, 24);
        check("bp_done", done, 1);
        fill(1'b0);
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("mid_valid", out_valid, k >= 1 ? 1 : 0);
            step();
        end
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_enb", bank0_enb, 0);
        step();
        rst_n = 1'b1;
        @(negedge clk);
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_ena", bank0_ena, 1);
        check("mid_rst_addra", bank0_addra, 0);
        check("mid_rst_idx", slicing_idx, 0);
        check("mid_rst_addrb", bank0_addrb, 0);
        step();
        @(negedge clk);
        check("mid_rst_no_done", done, 0);
        check("mid_rst_idx1", slicing_idx, 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
